// File: rtl/dcache_wb_buffer_pkg.sv
// ============================================================================
// dcache_wb_buffer_pkg : shared helpers for the dcache write-back buffer
// Revision : 1.0
// ============================================================================
`default_nettype none

package dcache_wb_buffer_pkg;

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  // One extra wrap bit lets full and empty be told apart with equal low bits.
  function automatic int ptr_width(input int d);
    return $clog2(d) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_wb_buffer_match.sv
// ============================================================================
// dcache_wb_buffer_match : depth-way line address compare, youngest-match pick
// Revision : 1.0
// ============================================================================
`default_nettype none

module dcache_wb_buffer_match #(
  parameter int depth           = 4,
  parameter int line_addr_width = 13
) (
  input  logic [depth-1:0]                      valid_i,
  input  logic [depth-1:0][line_addr_width-1:0] tags_i,
  input  logic [line_addr_width-1:0]            addr_i,
  input  logic [$clog2(depth)-1:0]              head_idx_i,
  input  logic                                  exclude_head_i,
  output logic [depth-1:0]                      match_o,
  output logic                                  hit_o,
  output logic [$clog2(depth)-1:0]              idx_o
);

  localparam int IDX_W = $clog2(depth);

  logic [IDX_W-1:0] scan_idx;

  always_comb begin
    match_o = '0;
    for (int i = 0; i < depth; i++) begin
      match_o[i] = valid_i[i] && (tags_i[i] == addr_i) &&
                   !(exclude_head_i && (IDX_W'(i) == head_idx_i));
    end
    hit_o = |match_o;

    // Walk from head towards the tail so the last hit is the youngest entry.
    idx_o    = head_idx_i;
    scan_idx = head_idx_i;
    for (int k = 0; k < depth; k++) begin
      scan_idx = head_idx_i + IDX_W'(k);
      if (match_o[scan_idx]) idx_o = scan_idx;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dcache_wb_buffer.sv
// ============================================================================
// dcache_wb_buffer : coalescing write-back FIFO between dcache eject and memory
// Revision : 1.0
// ============================================================================
`default_nettype none

module dcache_wb_buffer
  import dcache_wb_buffer_pkg::*;
#(
  parameter int addr_width      = 16,
  parameter int line_width      = 64,
  parameter int line_addr_width = addr_width - $clog2(line_width / 8),
  parameter int depth           = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       ejected_valid_i,
  input  logic [line_addr_width-1:0] ejected_addr_i,
  input  logic [line_width-1:0]      ejected_i,
  output logic                       full_o,
  output logic                       overflow_o,
  output logic                       empty_o,
  output logic [$clog2(depth):0]     count_o,
  output logic                       mem_valid_o,
  input  logic                       mem_ready_i,
  output logic [line_addr_width-1:0] mem_addr_o,
  output logic [line_width-1:0]      mem_data_o,
  input  logic                       snoop_valid_i,
  input  logic [line_addr_width-1:0] snoop_addr_i,
  output logic                       snoop_valid_o,
  output logic                       snoop_hit_o,
  output logic [line_width-1:0]      snoop_data_o
);

  localparam int PTR_W = ptr_width(depth);
  localparam int IDX_W = PTR_W - 1;

  generate
    if (line_width % 64 != 0) begin : g_bad_line_width
      $error("dcache_wb_buffer: line_width must be a multiple of 64");
    end
    if (!is_pow2(depth)) begin : g_bad_depth
      $error("dcache_wb_buffer: depth must be a power of two >= 2");
    end
  endgenerate

  typedef struct packed {
    logic                       valid;
    logic [line_addr_width-1:0] tag;
    logic [line_width-1:0]      data;
  } entry_t;

  entry_t [depth-1:0]      ent_q, ent_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic                    overflow_q, overflow_d;
  logic                    snoop_valid_q, snoop_valid_d;
  logic                    snoop_hit_q, snoop_hit_d;
  logic [line_width-1:0]   snoop_data_q, snoop_data_d;

  logic [depth-1:0]                      ent_valid;
  logic [depth-1:0][line_addr_width-1:0] ent_tags;
  logic [IDX_W-1:0]                      rd_idx, wr_idx;
  logic                                  full, empty, pop;
  logic [depth-1:0]                      co_match, sn_match;
  logic                                  co_hit, sn_hit;
  logic [IDX_W-1:0]                      co_idx, sn_idx;

  generate
    for (genvar g = 0; g < depth; g++) begin : g_unpack
      assign ent_valid[g] = ent_q[g].valid;
      assign ent_tags[g]  = ent_q[g].tag;
    end
  endgenerate

  assign rd_idx = rd_ptr_q[IDX_W-1:0];
  assign wr_idx = wr_ptr_q[IDX_W-1:0];
  assign empty  = (rd_ptr_q == wr_ptr_q);
  assign full   = (rd_ptr_q[PTR_W-1] != wr_ptr_q[PTR_W-1]) && (rd_idx == wr_idx);
  assign pop    = !empty && mem_ready_i;

  // Head is excluded from coalescing because it may be mid-handshake.
  dcache_wb_buffer_match #(.depth(depth), .line_addr_width(line_addr_width)) u_coalesce_match (
    .valid_i(ent_valid), .tags_i(ent_tags), .addr_i(ejected_addr_i), .head_idx_i(rd_idx),
    .exclude_head_i(1'b1), .match_o(co_match), .hit_o(co_hit), .idx_o(co_idx)
  );

  dcache_wb_buffer_match #(.depth(depth), .line_addr_width(line_addr_width)) u_snoop_match (
    .valid_i(ent_valid), .tags_i(ent_tags), .addr_i(snoop_addr_i), .head_idx_i(rd_idx),
    .exclude_head_i(1'b0), .match_o(sn_match), .hit_o(sn_hit), .idx_o(sn_idx)
  );

  always_comb begin
    ent_d      = ent_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    overflow_d = overflow_q;

    if (pop) begin
      ent_d[rd_idx].valid = 1'b0;
      rd_ptr_d            = rd_ptr_q + PTR_W'(1);
    end

    // Full is judged on pre-pop state: no pass-through into a full buffer.
    if (ejected_valid_i) begin
      if (co_hit) begin
        ent_d[co_idx].data = ejected_i;
      end else if (!full) begin
        ent_d[wr_idx] = '{valid: 1'b1, tag: ejected_addr_i, data: ejected_i};
        wr_ptr_d      = wr_ptr_q + PTR_W'(1);
      end else begin
        overflow_d = 1'b1;
      end
    end

    snoop_valid_d = snoop_valid_i;
    snoop_hit_d   = snoop_valid_i && sn_hit;
    snoop_data_d  = snoop_hit_d ? ent_q[sn_idx].data : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ent_q         <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      overflow_q    <= 1'b0;
      snoop_valid_q <= 1'b0;
      snoop_hit_q   <= 1'b0;
      snoop_data_q  <= '0;
    end else begin
      ent_q         <= ent_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      overflow_q    <= overflow_d;
      snoop_valid_q <= snoop_valid_d;
      snoop_hit_q   <= snoop_hit_d;
      snoop_data_q  <= snoop_data_d;
    end
  end

  assign full_o        = full;
  assign empty_o       = empty;
  assign count_o       = wr_ptr_q - rd_ptr_q;
  assign overflow_o    = overflow_q;
  assign mem_valid_o   = !empty;
  assign mem_addr_o    = ent_q[rd_idx].tag;
  assign mem_data_o    = ent_q[rd_idx].data;
  assign snoop_valid_o = snoop_valid_q;
  assign snoop_hit_o   = snoop_hit_q;
  assign snoop_data_o  = snoop_data_q;

endmodule

`default_nettype wire
